// File: rtl/fifo_arb_peer.sv
// Far-end peer of the two-client FIFO arbiter: decodes framed link bytes into two
// client write FIFOs and packs the two client read FIFOs round-robin into framed bursts.
module fifo_arb_peer #(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] SELMASK = 'h80,
  parameter logic [DW-1:0] CNTMASK = 'h70
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic          link_rden,
  input  logic          link_rdempty,
  input  logic [DW-1:0] link_rddata,
  output logic          link_wren,
  input  logic          link_wrfull,
  output logic [DW-1:0] link_wrdata,
  output logic          c1_wren,
  input  logic          c1_wrfull,
  output logic [DW-1:0] c1_wrdata,
  output logic          c2_wren,
  input  logic          c2_wrfull,
  output logic [DW-1:0] c2_wrdata,
  output logic          c1_rden,
  input  logic          c1_rdempty,
  input  logic [DW-1:0] c1_rddata,
  output logic          c2_rden,
  input  logic          c2_rdempty,
  input  logic [DW-1:0] c2_rddata,
  output logic          rx_err
);
  function automatic int lsb_idx(input logic [DW-1:0] m);
    lsb_idx = 0;
    for (int i = DW-1; i >= 0; i--) if (m[i]) lsb_idx = i;
  endfunction

  localparam int            SHIFT  = lsb_idx(CNTMASK);
  localparam int            MAXLEN = int'(CNTMASK >> SHIFT) + 1;
  localparam int            CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int            NW     = $clog2(MAXLEN + 1);
  localparam logic [DW-1:0] HDR_OK = SELMASK | CNTMASK;

  // ---------------- RX: link -> clients ----------------
  typedef enum logic {R_HDR, R_DATA} rx_state_t;
  rx_state_t     r_state, r_next;
  logic          sel, rx_pop, sink_full, hdr_bad;
  logic [CW-1:0] rcnt;

  assign hdr_bad   = |(link_rddata & ~HDR_OK);
  assign sink_full = sel ? c2_wrfull : c1_wrfull;
  assign link_rden = rx_pop;
  assign c1_wrdata = link_rddata;
  assign c2_wrdata = link_rddata;

  always_comb begin
    r_next  = r_state;
    rx_pop  = 1'b0;
    c1_wren = 1'b0;
    c2_wren = 1'b0;
    if (!RESET) begin
      case (r_state)
        R_HDR: if (!link_rdempty) begin
          rx_pop = 1'b1;
          if (!hdr_bad) r_next = R_DATA;
        end
        R_DATA: if (!link_rdempty && !sink_full) begin
          rx_pop  = 1'b1;
          c1_wren = !sel;
          c2_wren = sel;
          if (rcnt == '0) r_next = R_HDR;
        end
        default: r_next = R_HDR;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= R_HDR;
      sel     <= 1'b0;
      rcnt    <= '0;
      rx_err  <= 1'b0;
    end else begin
      r_state <= r_next;
      rx_err  <= (r_state == R_HDR) && rx_pop && hdr_bad;
      if (r_state == R_HDR && rx_pop && !hdr_bad) begin
        sel  <= |(link_rddata & SELMASK);
        rcnt <= CW'((link_rddata & CNTMASK) >> SHIFT);
      end
      if (r_state == R_DATA && rx_pop && rcnt != '0) rcnt <= rcnt - 1'b1;
    end
  end

  // ---------------- TX: clients -> link ----------------
  typedef enum logic [1:0] {T_IDLE, T_GATHER, T_HDR, T_DATA} tx_state_t;
  tx_state_t     t_state, t_next;
  logic          tsel, rr_ptr, pick, src_empty, gather_pop, t_wren;
  logic [DW-1:0] src_data, tx_len, tx_hdr;
  logic [NW-1:0] n;
  logic [CW-1:0] idx;
  logic [DW-1:0] tbuf [MAXLEN];

  // rr_ptr names the channel preferred when both have data
  assign pick      = (!c1_rdempty && !c2_rdempty) ? rr_ptr : c1_rdempty;
  assign src_empty = tsel ? c2_rdempty : c1_rdempty;
  assign src_data  = tsel ? c2_rddata : c1_rddata;
  assign tx_len    = DW'(n) - DW'(1);
  assign tx_hdr    = (tsel ? SELMASK : '0) | ((tx_len << SHIFT) & CNTMASK);
  assign link_wren   = t_wren;
  assign link_wrdata = (t_state == T_HDR) ? tx_hdr : tbuf[idx];
  assign c1_rden     = gather_pop && !tsel;
  assign c2_rden     = gather_pop && tsel;

  always_comb begin
    t_next     = t_state;
    gather_pop = 1'b0;
    t_wren     = 1'b0;
    if (!RESET) begin
      case (t_state)
        T_IDLE: if (!c1_rdempty || !c2_rdempty) t_next = T_GATHER;
        T_GATHER: begin
          if (!src_empty && n < NW'(MAXLEN)) begin
            gather_pop = 1'b1;
            if (n == NW'(MAXLEN - 1)) t_next = T_HDR;
          end else if (src_empty && n != '0) begin
            t_next = T_HDR;
          end
        end
        T_HDR: if (!link_wrfull) begin
          t_wren = 1'b1;
          t_next = T_DATA;
        end
        T_DATA: if (!link_wrfull) begin
          t_wren = 1'b1;
          if (NW'(idx) == n - 1'b1) t_next = T_IDLE;
        end
        default: t_next = T_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      t_state <= T_IDLE;
      tsel    <= 1'b0;
      rr_ptr  <= 1'b0;
      n       <= '0;
      idx     <= '0;
    end else begin
      t_state <= t_next;
      case (t_state)
        T_IDLE: if (t_next == T_GATHER) begin
          tsel <= pick;
          n    <= '0;
        end
        T_GATHER: if (gather_pop) n <= n + 1'b1;
        T_HDR:    if (t_wren) idx <= '0;
        T_DATA: if (t_wren) begin
          if (t_next == T_IDLE) rr_ptr <= ~tsel;
          else                  idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Burst staging needs no reset: n gates what is ever read back
  always_ff @(posedge CLK) begin
    if (gather_pop) tbuf[n[CW-1:0]] <= src_data;
  end
endmodule

// File: tb/tb_fifo_arb_peer.sv
// Scoreboard bench for fifo_arb_peer: directed link/client traffic, expected bytes
// queued at issue time and popped by a negedge monitor on every DUT push.
module tb_fifo_arb_peer;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       link_rden, link_rdempty, link_wren, link_wrfull;
  logic [7:0] link_rddata, link_wrdata;
  logic       c1_wren, c1_wrfull, c2_wren, c2_wrfull;
  logic [7:0] c1_wrdata, c2_wrdata;
  logic       c1_rden, c1_rdempty, c2_rden, c2_rdempty;
  logic [7:0] c1_rddata, c2_rddata;
  logic       rx_err;

  always #5 CLK = ~CLK;

  fifo_arb_peer #(.DW(8), .SELMASK(8'h80), .CNTMASK(8'h70)) dut (
    .CLK(CLK), .RESET(RESET),
    .link_rden(link_rden), .link_rdempty(link_rdempty), .link_rddata(link_rddata),
    .link_wren(link_wren), .link_wrfull(link_wrfull), .link_wrdata(link_wrdata),
    .c1_wren(c1_wren), .c1_wrfull(c1_wrfull), .c1_wrdata(c1_wrdata),
    .c2_wren(c2_wren), .c2_wrfull(c2_wrfull), .c2_wrdata(c2_wrdata),
    .c1_rden(c1_rden), .c1_rdempty(c1_rdempty), .c1_rddata(c1_rddata),
    .c2_rden(c2_rden), .c2_rdempty(c2_rdempty), .c2_rddata(c2_rddata),
    .rx_err(rx_err)
  );

  // first-word fall-through source FIFOs
  logic [7:0] lmem [256];
  logic [7:0] c1m  [256];
  logic [7:0] c2m  [256];
  logic [7:0] lwp = 8'd0, lrp = 8'd0, c1wp = 8'd0, c1rp = 8'd0, c2wp = 8'd0, c2rp = 8'd0;

  assign link_rdempty = (lwp == lrp);
  assign link_rddata  = lmem[lrp];
  assign c1_rdempty   = (c1wp == c1rp);
  assign c1_rddata    = c1m[c1rp];
  assign c2_rdempty   = (c2wp == c2rp);
  assign c2_rddata    = c2m[c2rp];

  always @(posedge CLK) begin
    if (link_rden && lwp != lrp)   lrp  <= lrp + 8'd1;
    if (c1_rden   && c1wp != c1rp) c1rp <= c1rp + 8'd1;
    if (c2_rden   && c2wp != c2rp) c2rp <= c2rp + 8'd1;
  end

  logic [7:0] exp_c1[$], exp_c2[$], exp_l[$];
  int n_chk = 0, n_fail = 0, err_cnt = 0, c2_cnt = 0;
  logic [7:0] e;

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (c1_wren) begin
      n_chk++;
      if (exp_c1.size() == 0) begin
        n_fail++; $display("FAIL c1_wr: unexpected byte %h", c1_wrdata);
      end else begin
        e = exp_c1.pop_front();
        if (c1_wrdata !== e || c1_wrfull) begin
          n_fail++; $display("FAIL c1_wr: got %h (full=%b) expected %h", c1_wrdata, c1_wrfull, e);
        end
      end
    end
    if (c2_wren) begin
      n_chk++; c2_cnt++;
      if (exp_c2.size() == 0) begin
        n_fail++; $display("FAIL c2_wr: unexpected byte %h", c2_wrdata);
      end else begin
        e = exp_c2.pop_front();
        if (c2_wrdata !== e || c2_wrfull) begin
          n_fail++; $display("FAIL c2_wr: got %h (full=%b) expected %h", c2_wrdata, c2_wrfull, e);
        end
      end
    end
    if (link_wren) begin
      n_chk++;
      if (exp_l.size() == 0) begin
        n_fail++; $display("FAIL link_wr: unexpected byte %h", link_wrdata);
      end else begin
        e = exp_l.pop_front();
        if (link_wrdata !== e || link_wrfull) begin
          n_fail++; $display("FAIL link_wr: got %h (full=%b) expected %h", link_wrdata, link_wrfull, e);
        end
      end
    end
    if (link_rden || c1_rden || c2_rden) begin
      n_chk++;
      if ((link_rden && link_rdempty) || (c1_rden && c1_rdempty) || (c2_rden && c2_rdempty)) begin
        n_fail++; $display("FAIL pop_empty: rden=%b%b%b empty=%b%b%b expected no pop from empty",
                           link_rden, c1_rden, c2_rden, link_rdempty, c1_rdempty, c2_rdempty);
      end
    end
    if (rx_err === 1'b1) err_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++; $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_strobes(input string nm);
    check(nm, 32'({link_rden, link_wren, c1_wren, c2_wren, c1_rden, c2_rden}), 32'd0);
  endtask

  task automatic push_link(input logic [7:0] b); lmem[lwp] = b; lwp = lwp + 8'd1; endtask
  task automatic push_c1(input logic [7:0] b);   c1m[c1wp] = b; c1wp = c1wp + 8'd1; endtask
  task automatic push_c2(input logic [7:0] b);   c2m[c2wp] = b; c2wp = c2wp + 8'd1; endtask

  // wait for every expected byte to appear and every source to drain, then idle a few cycles
  task automatic drain(input string nm);
    int cyc = 0;
    while ((exp_c1.size() != 0 || exp_c2.size() != 0 || exp_l.size() != 0 ||
            lwp != lrp || c1wp != c1rp || c2wp != c2rp) && cyc < 300) begin
      @(negedge CLK); cyc++;
    end
    n_chk++;
    if (cyc >= 300) begin
      n_fail++;
      $display("FAIL %s: timeout, pending c1=%0d c2=%0d link=%0d expected all 0",
               nm, exp_c1.size(), exp_c2.size(), exp_l.size());
      exp_c1.delete(); exp_c2.delete(); exp_l.delete();
    end
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, cyc;
    RESET = 1'b1; link_wrfull = 1'b0; c1_wrfull = 1'b0; c2_wrfull = 1'b0;
    repeat (3) begin @(negedge CLK); chk_strobes("reset strobes"); end
    check("rx_err after reset", 32'(rx_err), 32'd0);
    @(posedge CLK); #1 RESET = 1'b0;

    // reset in the middle of an RX frame and a TX burst
    push_link(8'h30); push_link(8'h11); push_link(8'h22);
    exp_c1.push_back(8'h11); exp_c1.push_back(8'h22);
    link_wrfull = 1'b1;
    push_c2(8'hD0); push_c2(8'hD1); push_c2(8'hD2); push_c2(8'hD3);
    repeat (10) @(posedge CLK);
    #1 check("rx partial frame delivered", 32'(exp_c1.size()), 32'd0);
    exp_l.push_back(8'hB0);
    link_wrfull = 1'b0;
    @(posedge CLK); #1 link_wrfull = 1'b1;
    repeat (2) @(posedge CLK);
    #1 check("tx header before reset", 32'(exp_l.size()), 32'd0);
    RESET = 1'b1;
    push_link(8'h00); push_link(8'hAA); push_c1(8'h3C);
    link_wrfull = 1'b0;
    repeat (3) begin @(negedge CLK); chk_strobes("strobes during mid-frame reset"); end
    exp_c1.push_back(8'hAA);
    exp_l.push_back(8'h00); exp_l.push_back(8'h3C);
    @(posedge CLK); #1 RESET = 1'b0;
    drain("reset recovery");

    // RX decode: 1-byte ch1 frame then 8-byte ch2 frame
    push_link(8'h00); push_link(8'hA5); push_link(8'hF0);
    exp_c1.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin push_link(8'(i)); exp_c2.push_back(8'(i)); end
    drain("rx decode");

    // RX backpressure from c2 mid-payload
    base = c2_cnt;
    push_link(8'hF0);
    for (int i = 0; i < 8; i++) begin push_link(8'h10 + 8'(i)); exp_c2.push_back(8'h10 + 8'(i)); end
    cyc = 0;
    while (c2_cnt - base < 3 && cyc < 50) begin @(negedge CLK); cyc++; end
    check("c2 payload started", 32'(c2_cnt - base >= 3), 32'd1);
    @(posedge CLK); #1 c2_wrfull = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("no link pop while c2 full", 32'({link_rden, c2_wren, c1_wren}), 32'd0);
    end
    @(posedge CLK); #1 c2_wrfull = 1'b0;
    drain("rx backpressure");

    // malformed headers: 01 is one bad header; 12 and A5 are both bad as headers
    base = err_cnt;
    push_link(8'h01); push_link(8'h00); push_link(8'h5C);
    exp_c1.push_back(8'h5C);
    drain("malformed 01");
    check("rx_err cycles for 01", 32'(err_cnt - base), 32'd1);
    base = err_cnt;
    push_link(8'h12); push_link(8'hA5); push_link(8'h00); push_link(8'hA5);
    exp_c1.push_back(8'hA5);
    drain("malformed 12 A5");
    check("rx_err cycles for 12 A5", 32'(err_cnt - base), 32'd2);

    // TX round-robin with burst cap, from a fresh round-robin pointer
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    for (int i = 0; i < 10; i++) push_c1(8'h80 + 8'(i));
    push_c2(8'hC0); push_c2(8'hC1); push_c2(8'hC2);
    exp_l.push_back(8'h70);
    for (int i = 0; i < 8; i++) exp_l.push_back(8'h80 + 8'(i));
    exp_l.push_back(8'hA0);
    exp_l.push_back(8'hC0); exp_l.push_back(8'hC1); exp_l.push_back(8'hC2);
    exp_l.push_back(8'h10); exp_l.push_back(8'h88); exp_l.push_back(8'h89);
    drain("tx round robin");

    // TX with link_wrfull toggling every cycle
    for (int i = 0; i < 4; i++) push_c2(8'hE0 + 8'(i));
    exp_l.push_back(8'hB0);
    for (int i = 0; i < 4; i++) exp_l.push_back(8'hE0 + 8'(i));
    cyc = 0;
    while (exp_l.size() != 0 && cyc < 100) begin
      @(posedge CLK); #1 link_wrfull = ~link_wrfull; cyc++;
    end
    link_wrfull = 1'b0;
    drain("tx link backpressure");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
